// File: rtl/ysyx_25030081_rf_ctrl_if.sv
// Bundle of issue, writeback-request and RF write-port signals around the RF controller.
// The slave modport is the controller's view; the master modport is the surrounding pipeline's view.
interface ysyx_25030081_rf_ctrl_if #(
   parameter int unsigned RF_ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32
);
   localparam int unsigned NUM_REGS = 1 << RF_ADDR_WIDTH;

   logic                     issue_valid;
   logic                     issue_wen;
   logic [RF_ADDR_WIDTH-1:0] issue_rd;
   logic [RF_ADDR_WIDTH-1:0] issue_rs1;
   logic [RF_ADDR_WIDTH-1:0] issue_rs2;
   logic                     issue_ready;

   logic                     ex_valid;
   logic [RF_ADDR_WIDTH-1:0] ex_rd;
   logic [DATA_WIDTH-1:0]    ex_data;
   logic                     ex_ready;

   logic                     ls_valid;
   logic [RF_ADDR_WIDTH-1:0] ls_rd;
   logic [DATA_WIDTH-1:0]    ls_data;
   logic                     ls_ready;

   logic                     rf_wen;
   logic [RF_ADDR_WIDTH-1:0] rf_waddr;
   logic [DATA_WIDTH-1:0]    rf_wdata;
   logic [NUM_REGS-1:0]      busy_vec;

   modport slave (
      input  issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
      input  ex_valid, ex_rd, ex_data,
      input  ls_valid, ls_rd, ls_data,
      output issue_ready, ex_ready, ls_ready,
      output rf_wen, rf_waddr, rf_wdata, busy_vec
   );

   modport master (
      output issue_valid, issue_wen, issue_rd, issue_rs1, issue_rs2,
      output ex_valid, ex_rd, ex_data,
      output ls_valid, ls_rd, ls_data,
      input  issue_ready, ex_ready, ls_ready,
      input  rf_wen, rf_waddr, rf_wdata, busy_vec
   );
endinterface

// File: rtl/ysyx_25030081_rf_ctrl.sv
// RF write-port controller: round-robin EX/LS writeback arbiter with a registered write,
// plus a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module ysyx_25030081_rf_ctrl #(
   parameter int unsigned RF_ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH    = 32
) (
   input logic                    clk,
   input logic                    rst,
   ysyx_25030081_rf_ctrl_if.slave bus
);
   localparam int unsigned NUM_REGS = 1 << RF_ADDR_WIDTH;

   typedef enum logic {
      LAST_EX = 1'b0,
      LAST_LS = 1'b1
   } rr_e;

   rr_e                      last_q, last_d;
   logic                     rf_wen_q, rf_wen_d;
   logic [RF_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
   logic [DATA_WIDTH-1:0]    rf_wdata_q, rf_wdata_d;
   logic [NUM_REGS-1:0]      busy_q, busy_d;

   logic ex_gnt_c;
   logic ls_gnt_c;
   logic issue_ready_c;
   logic issue_fire_c;

   // State register; reset leaves the pointer at LS so EX wins the first contention.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q     <= LAST_LS;
         rf_wen_q   <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         busy_q     <= '0;
      end else begin
         last_q     <= last_d;
         rf_wen_q   <= rf_wen_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         busy_q     <= busy_d;
      end
   end

   // Grant, write-stage next state, hazard check and scoreboard update.
   always_comb begin
      last_d        = last_q;
      rf_wen_d      = 1'b0;
      rf_waddr_d    = rf_waddr_q;
      rf_wdata_d    = rf_wdata_q;
      busy_d        = busy_q;

      ex_gnt_c      = bus.ex_valid && (!bus.ls_valid || (last_q == LAST_LS));
      ls_gnt_c      = bus.ls_valid && (!bus.ex_valid || (last_q == LAST_EX));

      issue_ready_c = !(busy_q[bus.issue_rs1] || busy_q[bus.issue_rs2] ||
                        (bus.issue_wen && busy_q[bus.issue_rd]));
      issue_fire_c  = bus.issue_valid && issue_ready_c;

      if (ex_gnt_c) begin
         last_d     = LAST_EX;
         rf_wen_d   = (bus.ex_rd != '0);
         rf_waddr_d = bus.ex_rd;
         rf_wdata_d = bus.ex_data;
      end else if (ls_gnt_c) begin
         last_d     = LAST_LS;
         rf_wen_d   = (bus.ls_rd != '0);
         rf_waddr_d = bus.ls_rd;
         rf_wdata_d = bus.ls_data;
      end

      // Clear first so a same-edge set on the same bit wins.
      if (rf_wen_q) begin
         busy_d[rf_waddr_q] = 1'b0;
      end
      if (issue_fire_c && bus.issue_wen && (bus.issue_rd != '0)) begin
         busy_d[bus.issue_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   assign bus.issue_ready = issue_ready_c;
   assign bus.ex_ready    = ex_gnt_c;
   assign bus.ls_ready    = ls_gnt_c;
   assign bus.rf_wen      = rf_wen_q;
   assign bus.rf_waddr    = rf_waddr_q;
   assign bus.rf_wdata    = rf_wdata_q;
   assign bus.busy_vec    = busy_q;
endmodule

// File: tb/tb_ysyx_25030081_rf_ctrl.sv
// Self-checking bench for ysyx_25030081_rf_ctrl: per-scenario tasks plus a scoreboard
// of expected RF writes that a negedge monitor pops and compares.
module tb_ysyx_25030081_rf_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;

   ysyx_25030081_rf_ctrl_if #(.RF_ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

   ysyx_25030081_rf_ctrl #(.RF_ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [4:0]  addr;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   mon_en = 1'b0;
   bit   model_last_ls = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   // Write-port monitor: every cycle the RF write outputs must match the due entry, or be idle.
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            n_vec++;
            if (bus.rf_wen !== e.wen || bus.rf_waddr !== e.addr || bus.rf_wdata !== e.data) begin
               n_err++;
               $display("FAIL wb_out cyc=%0d: got wen=%b addr=%0d data=%h, exp wen=%b addr=%0d data=%h",
                        cyc, bus.rf_wen, bus.rf_waddr, bus.rf_wdata, e.wen, e.addr, e.data);
            end
         end else begin
            n_vec++;
            if (bus.rf_wen !== 1'b0) begin
               n_err++;
               $display("FAIL wb_idle cyc=%0d: got rf_wen=%b exp 0", cyc, bus.rf_wen);
            end
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
               e = exp_q.pop_front();
               n_err++;
               $display("FAIL wb_missed cyc=%0d: write to x%0d due cyc %0d never observed", cyc, e.addr, e.due);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-robin reference: returns {ex_grant, ls_grant} and advances the pointer.
   function automatic logic [1:0] model_grant(input logic ev, input logic lv);
      logic ge, gl;
      ge = ev && (!lv || model_last_ls);
      gl = lv && (!ev || !model_last_ls);
      if (ge) model_last_ls = 1'b0;
      else if (gl) model_last_ls = 1'b1;
      return {ge, gl};
   endfunction

   function automatic void push_exp(input logic [4:0] rd, input logic [31:0] data);
      exp_t e;
      e.wen  = (rd != 5'd0);
      e.addr = rd;
      e.data = data;
      e.due  = cyc + 1;
      exp_q.push_back(e);
   endfunction

   task automatic drive_idle();
      bus.issue_valid = 1'b0; bus.issue_wen = 1'b0;
      bus.issue_rd = 5'd0; bus.issue_rs1 = 5'd0; bus.issue_rs2 = 5'd0;
      bus.ex_valid = 1'b0; bus.ex_rd = 5'd0; bus.ex_data = 32'd0;
      bus.ls_valid = 1'b0; bus.ls_rd = 5'd0; bus.ls_data = 32'd0;
   endtask

   task automatic test_reset();
      logic [1:0] g;
      drive_idle();
      rst = 1'b1;
      repeat (2) tick();
      n_vec++;
      if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0 || bus.busy_vec !== 32'd0) begin
         n_err++;
         $display("FAIL reset_state: got wen=%b addr=%0d data=%h busy=%h exp all 0",
                  bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.busy_vec);
      end
      rst = 1'b0;
      model_last_ls = 1'b1;
      mon_en = 1'b1;
      // Build busy = 0x24 and an in-flight write, then hit reset.
      bus.issue_valid = 1'b1; bus.issue_wen = 1'b1; bus.issue_rd = 5'd2;
      #1;
      n_vec++;
      if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_issue_x2: got %b exp 1", bus.issue_ready); end
      tick();
      bus.issue_rd = 5'd5;
      tick();
      bus.issue_valid = 1'b0;
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd9; bus.ex_data = 32'h0000_00A5;
      #1;
      g = model_grant(1'b1, 1'b0);
      n_vec++;
      if (bus.ex_ready !== g[1]) begin n_err++; $display("FAIL reset_ex_ready: got %b exp %b", bus.ex_ready, g[1]); end
      push_exp(5'd9, 32'h0000_00A5);
      tick();
      bus.ex_valid = 1'b0;
      #1;
      n_vec++;
      if (bus.rf_wen !== 1'b1 || bus.busy_vec !== 32'h0000_0024) begin
         n_err++;
         $display("FAIL pre_reset: got wen=%b busy=%h exp wen=1 busy=00000024", bus.rf_wen, bus.busy_vec);
      end
      rst = 1'b1;
      exp_q.delete();
      #1;
      n_vec++;
      if (bus.rf_wen !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0 || bus.busy_vec !== 32'd0) begin
         n_err++;
         $display("FAIL midrun_reset: got wen=%b addr=%0d data=%h busy=%h exp all 0",
                  bus.rf_wen, bus.rf_waddr, bus.rf_wdata, bus.busy_vec);
      end
      tick();
      tick();
      rst = 1'b0;
      model_last_ls = 1'b1;
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd1; bus.ex_data = 32'h11;
      bus.ls_valid = 1'b1; bus.ls_rd = 5'd2; bus.ls_data = 32'h22;
      #1;
      g = model_grant(1'b1, 1'b1);
      n_vec++;
      if (bus.ex_ready !== 1'b1 || bus.ls_ready !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_first_grant: got ex=%b ls=%b exp ex=1 ls=0", bus.ex_ready, bus.ls_ready);
      end
      push_exp(5'd1, 32'h11);
      tick();
      drive_idle();
      tick();
   endtask

   task automatic test_single();
      logic [1:0] g;
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd5; bus.ex_data = 32'hDEAD_BEEF;
      #1;
      g = model_grant(1'b1, 1'b0);
      n_vec++;
      if (bus.ex_ready !== g[1] || bus.ls_ready !== g[0]) begin
         n_err++;
         $display("FAIL single_ready: got ex=%b ls=%b exp ex=%b ls=%b", bus.ex_ready, bus.ls_ready, g[1], g[0]);
      end
      push_exp(5'd5, 32'hDEAD_BEEF);
      tick();
      drive_idle();
      repeat (2) tick();
   endtask

   task automatic test_nonbusy();
      logic [1:0] g;
      bus.issue_valid = 1'b1; bus.issue_wen = 1'b1; bus.issue_rd = 5'd4;
      #1;
      n_vec++;
      if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL nonbusy_issue_x4: got %b exp 1", bus.issue_ready); end
      tick();
      drive_idle();
      bus.ls_valid = 1'b1; bus.ls_rd = 5'd9; bus.ls_data = 32'h99;
      #1;
      g = model_grant(1'b0, 1'b1);
      n_vec++;
      if (bus.ls_ready !== g[0] || bus.ex_ready !== g[1]) begin
         n_err++;
         $display("FAIL nonbusy_ls_ready: got ls=%b ex=%b exp ls=%b ex=%b", bus.ls_ready, bus.ex_ready, g[0], g[1]);
      end
      push_exp(5'd9, 32'h99);
      tick();
      drive_idle();
      tick();
      n_vec++;
      if (bus.busy_vec !== 32'h0000_0010) begin
         n_err++;
         $display("FAIL nonbusy_busy: got %h exp 00000010", bus.busy_vec);
      end
      // Retire x4 through the LS port.
      bus.ls_valid = 1'b1; bus.ls_rd = 5'd4; bus.ls_data = 32'h44;
      #1;
      g = model_grant(1'b0, 1'b1);
      push_exp(5'd4, 32'h44);
      tick();
      drive_idle();
      repeat (2) tick();
      n_vec++;
      if (bus.busy_vec !== 32'd0) begin n_err++; $display("FAIL nonbusy_clear_x4: got %h exp 0", bus.busy_vec); end
   endtask

   task automatic test_contention();
      logic [1:0] g;
      logic       exp_ex;
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd1; bus.ex_data = 32'h11;
      bus.ls_valid = 1'b1; bus.ls_rd = 5'd2; bus.ls_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         exp_ex = (i % 2 == 0);
         g = model_grant(1'b1, 1'b1);
         n_vec++;
         if (bus.ex_ready !== exp_ex || bus.ls_ready !== !exp_ex) begin
            n_err++;
            $display("FAIL contention_grant[%0d]: got ex=%b ls=%b exp ex=%b ls=%b",
                     i, bus.ex_ready, bus.ls_ready, exp_ex, !exp_ex);
         end
         if (exp_ex) push_exp(5'd1, 32'h11);
         else        push_exp(5'd2, 32'h22);
         tick();
      end
      drive_idle();
      repeat (2) tick();
   endtask

   task automatic test_raw();
      logic [1:0] g;
      bus.issue_valid = 1'b1; bus.issue_wen = 1'b1; bus.issue_rd = 5'd7;
      #1;
      n_vec++;
      if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL raw_issue_x7: got %b exp 1", bus.issue_ready); end
      tick();
      bus.issue_rd = 5'd8; bus.issue_rs1 = 5'd7; bus.issue_rs2 = 5'd0;
      #1;
      n_vec++;
      if (bus.issue_ready !== 1'b0 || bus.busy_vec !== 32'h0000_0080) begin
         n_err++;
         $display("FAIL raw_stall: got ready=%b busy=%h exp ready=0 busy=00000080", bus.issue_ready, bus.busy_vec);
      end
      tick();
      bus.ls_valid = 1'b1; bus.ls_rd = 5'd7; bus.ls_data = 32'h77;
      #1;
      g = model_grant(1'b0, 1'b1);
      n_vec++;
      if (bus.ls_ready !== g[0] || bus.issue_ready !== 1'b0) begin
         n_err++;
         $display("FAIL raw_ls_grant: got ls=%b ready=%b exp ls=%b ready=0", bus.ls_ready, bus.issue_ready, g[0]);
      end
      push_exp(5'd7, 32'h77);
      tick();
      bus.ls_valid = 1'b0;
      #1;
      n_vec++;
      if (bus.issue_ready !== 1'b0 || bus.busy_vec !== 32'h0000_0080) begin
         n_err++;
         $display("FAIL raw_wen_cycle: got ready=%b busy=%h exp ready=0 busy=00000080", bus.issue_ready, bus.busy_vec);
      end
      tick();
      n_vec++;
      if (bus.issue_ready !== 1'b1 || bus.busy_vec !== 32'd0) begin
         n_err++;
         $display("FAIL raw_release: got ready=%b busy=%h exp ready=1 busy=0", bus.issue_ready, bus.busy_vec);
      end
      tick();
      drive_idle();
      #1;
      n_vec++;
      if (bus.busy_vec !== 32'h0000_0100) begin n_err++; $display("FAIL raw_set_x8: got %h exp 00000100", bus.busy_vec); end
      bus.ls_valid = 1'b1; bus.ls_rd = 5'd8; bus.ls_data = 32'h88;
      #1;
      g = model_grant(1'b0, 1'b1);
      push_exp(5'd8, 32'h88);
      tick();
      drive_idle();
      repeat (2) tick();
   endtask

   task automatic test_waw_x0();
      logic [1:0] g;
      bus.issue_valid = 1'b1; bus.issue_wen = 1'b1; bus.issue_rd = 5'd3;
      #1;
      n_vec++;
      if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_first: got %b exp 1", bus.issue_ready); end
      tick();
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd3; bus.ex_data = 32'h3333;
      #1;
      g = model_grant(1'b1, 1'b0);
      n_vec++;
      if (bus.issue_ready !== 1'b0 || bus.ex_ready !== g[1]) begin
         n_err++;
         $display("FAIL waw_stall: got ready=%b ex=%b exp ready=0 ex=%b", bus.issue_ready, bus.ex_ready, g[1]);
      end
      push_exp(5'd3, 32'h3333);
      tick();
      bus.ex_valid = 1'b0;
      #1;
      n_vec++;
      if (bus.issue_ready !== 1'b0) begin n_err++; $display("FAIL waw_wen_cycle: got %b exp 0", bus.issue_ready); end
      tick();
      n_vec++;
      if (bus.issue_ready !== 1'b1) begin n_err++; $display("FAIL waw_release: got %b exp 1", bus.issue_ready); end
      tick();
      bus.issue_rd = 5'd0;
      #1;
      n_vec++;
      if (bus.issue_ready !== 1'b1 || bus.busy_vec !== 32'h0000_0008) begin
         n_err++;
         $display("FAIL x0_issue: got ready=%b busy=%h exp ready=1 busy=00000008", bus.issue_ready, bus.busy_vec);
      end
      tick();
      drive_idle();
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.ex_data = 32'h1234;
      #1;
      g = model_grant(1'b1, 1'b0);
      n_vec++;
      if (bus.ex_ready !== 1'b1 || bus.busy_vec !== 32'h0000_0008) begin
         n_err++;
         $display("FAIL x0_write: got ex=%b busy=%h exp ex=1 busy=00000008", bus.ex_ready, bus.busy_vec);
      end
      push_exp(5'd0, 32'h1234);
      tick();
      bus.ex_rd = 5'd3; bus.ex_data = 32'h3334;
      #1;
      g = model_grant(1'b1, 1'b0);
      push_exp(5'd3, 32'h3334);
      tick();
      drive_idle();
      repeat (2) tick();
      n_vec++;
      if (bus.busy_vec !== 32'd0) begin n_err++; $display("FAIL waw_final_busy: got %h exp 0", bus.busy_vec); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_nonbusy();
      test_contention();
      test_raw();
      test_waw_x0();
      repeat (3) tick();
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d pending writes exp 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end
endmodule
